// File: rtl/de2_115_lcd_bus_sequencer.sv
// HD44780 16x2 LCD bus timing engine: power-on delay, E/RS/RW/DB sequencing, execution waits.
// Optional `LCD_BUSY_POLL_EN replaces the fixed write waits with busy-flag polling.
module de2_115_lcd_bus_sequencer #(
  parameter int unsigned T_AS_CYC     = 3,
  parameter int unsigned T_PW_CYC     = 12,
  parameter int unsigned T_H_CYC      = 2,
  parameter int unsigned T_CYC_CYC    = 25,
  parameter int unsigned POWER_ON_CYC = 750000,
  parameter int unsigned SHORT_WAIT   = 2000,
  parameter int unsigned LONG_WAIT    = 82000,
  parameter int unsigned POLL_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy_timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  typedef enum logic [2:0] {
    StPwron, StIdle, StSetup, StPulse, StHold, StRecover, StWait
  } state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [31:0] cyc_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_data_q;
  logic        e_q;
  logic        lcd_rs_q;
  logic        lcd_rw_q;
  logic        db_oe_q;
  logic [7:0]  db_q;
  logic        xfer_done;
  logic [31:0] wait_len;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // True on the final cycle of a phase lasting len cycles (len of 0 behaves as 1).
  function automatic logic last_cycle(input logic [31:0] cnt, input logic [31:0] len);
    return ({1'b0, cnt} + 33'd1) >= {1'b0, len};
  endfunction

  always_comb begin
    xfer_done = 1'b0;
    if (state_q == StHold) begin
      xfer_done = last_cycle(cnt_q, T_H_CYC) && (cyc_q >= T_CYC_CYC);
    end else if (state_q == StRecover) begin
      xfer_done = (cyc_q >= T_CYC_CYC);
    end
  end

  // Clear display (0x01) and return home (0x02/0x03) need the long execution time.
  assign wait_len = (!lcd_rs_q && (db_q[7:2] == 6'd0)) ? LONG_WAIT : SHORT_WAIT;

`ifdef LCD_BUSY_POLL_EN
  logic        poll_q;
  logic        busy_q;
  logic        busy_timeout_q;
  logic [31:0] poll_cnt_q;
  assign busy_timeout = busy_timeout_q;
`else
  assign busy_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StPwron;
      cnt_q       <= 32'd0;
      cyc_q       <= 32'd0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      e_q         <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_rw_q    <= 1'b1;
      db_oe_q     <= 1'b0;
      db_q        <= 8'd0;
`ifdef LCD_BUSY_POLL_EN
      poll_q         <= 1'b0;
      busy_q         <= 1'b0;
      busy_timeout_q <= 1'b0;
      poll_cnt_q     <= 32'd0;
`endif
    end else begin
      cnt_q       <= sat_inc(cnt_q);
      cyc_q       <= sat_inc(cyc_q);
      rsp_valid_q <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      if (poll_q) poll_cnt_q <= sat_inc(poll_cnt_q);
`endif
      unique case (state_q)
        StPwron: begin
          if (last_cycle(cnt_q, POWER_ON_CYC)) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
          end
        end
        StIdle: begin
          if (cmd_valid) begin
            state_q     <= StSetup;
            cmd_ready_q <= 1'b0;
            lcd_rs_q    <= cmd_rs;
            lcd_rw_q    <= cmd_rw;
            db_q        <= cmd_data;
            db_oe_q     <= !cmd_rw;
            cnt_q       <= 32'd0;
            cyc_q       <= 32'd1;
`ifdef LCD_BUSY_POLL_EN
            poll_q         <= 1'b0;
            busy_timeout_q <= 1'b0;
`endif
          end
        end
        StSetup: begin
          if (last_cycle(cnt_q, T_AS_CYC)) begin
            state_q <= StPulse;
            e_q     <= 1'b1;
            cnt_q   <= 32'd0;
          end
        end
        StPulse: begin
          if (last_cycle(cnt_q, T_PW_CYC)) begin
            state_q <= StHold;
            e_q     <= 1'b0;
            cnt_q   <= 32'd0;
            if (lcd_rw_q) begin
`ifdef LCD_BUSY_POLL_EN
              if (poll_q) begin
                busy_q <= LCD_data[7];
              end else begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= LCD_data;
              end
`else
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= LCD_data;
`endif
            end
          end
        end
        StHold: begin
          if (last_cycle(cnt_q, T_H_CYC) && !xfer_done) state_q <= StRecover;
        end
        StRecover: begin
        end
        StWait: begin
          if (last_cycle(cnt_q, wait_len)) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= StPwron;
      endcase

      // End of a bus cycle: release the bus, then decide what follows.
      if (xfer_done) begin
        lcd_rw_q <= 1'b1;
        db_oe_q  <= 1'b0;
        cnt_q    <= 32'd0;
        if (!lcd_rw_q) begin
`ifdef LCD_BUSY_POLL_EN
          state_q    <= StSetup;
          lcd_rs_q   <= 1'b0;
          cyc_q      <= 32'd1;
          poll_q     <= 1'b1;
          poll_cnt_q <= 32'd0;
`else
          state_q <= StWait;
`endif
        end else begin
`ifdef LCD_BUSY_POLL_EN
          if (poll_q && busy_q && (poll_cnt_q < POLL_TIMEOUT)) begin
            state_q <= StSetup;
            cyc_q   <= 32'd1;
          end else begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            poll_q      <= 1'b0;
            if (poll_q && busy_q) busy_timeout_q <= 1'b1;
          end
`else
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
`endif
        end
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign LCD_E     = e_q;
  assign LCD_RS    = lcd_rs_q;
  assign LCD_RW    = lcd_rw_q;
  assign LCD_data  = db_oe_q ? db_q : 8'hzz;

endmodule

// File: tb/tb_de2_115_lcd_bus_sequencer.sv
// Bench for de2_115_lcd_bus_sequencer: directed transfers, read scoreboard, reset and timing checks.
module tb_de2_115_lcd_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic       cmd_rw;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy_timeout;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  wire  [7:0] lcd_data;
  logic [7:0] lcd_model;

  int passes = 0;
  int total  = 0;
  logic [7:0] sb_q[$];
  logic       rsp_prev = 1'b0;

  always #5 clk = ~clk;

  // LCD model drives the bus whenever RW=1; any DUT drive then corrupts the observed value.
  assign lcd_data = LCD_RW ? lcd_model : 8'hzz;

  de2_115_lcd_bus_sequencer #(
    .POWER_ON_CYC(100),
    .SHORT_WAIT  (50),
    .LONG_WAIT   (400),
    .POLL_TIMEOUT(2000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rs      (cmd_rs),
    .cmd_rw      (cmd_rw),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy_timeout(busy_timeout),
    .LCD_E       (LCD_E),
    .LCD_RS      (LCD_RS),
    .LCD_RW      (LCD_RW),
    .LCD_data    (lcd_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      check("rsp_single_pulse", {31'd0, rsp_prev}, 32'd0);
      check("rsp_expected", {31'd0, (sb_q.size() != 0)}, 32'd1);
      if (sb_q.size() != 0) check("rsp_data", {24'd0, rsp_data}, {24'd0, sb_q.pop_front()});
    end
    rsp_prev = reset_n && rsp_valid;
  end

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!cmd_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({tag, " ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  // Call at a negedge: releases reset and checks the power-on interval.
  task automatic power_on_check(input string tag);
    reset_n = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      check({tag, " pwron_ready"}, {31'd0, cmd_ready}, {31'd0, (n == 100)});
      check({tag, " pwron_bus"}, {22'd0, LCD_E, LCD_RW, lcd_data}, {22'd0, 1'b0, 1'b1, lcd_model});
    end
  endtask

  task automatic do_xfer(input logic rs, input logic rw, input logic [7:0] data,
                         input int exp_lat, input bit hold_valid, input string tag);
    int n = 0;
    logic [7:0] exp_db;
    wait_ready(tag);
    cmd_rs    = rs;
    cmd_rw    = rw;
    cmd_data  = data;
    cmd_valid = 1'b1;
    if (rw) sb_q.push_back(lcd_model);
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (!hold_valid || n == 30) cmd_valid = 1'b0;
      if (hold_valid && n == 2) cmd_data = 8'hFF;
      if (cmd_ready) break;
      if (n <= 17) begin
        exp_db = rw ? lcd_model : data;
        check({tag, " bus"}, {22'd0, LCD_RS, LCD_RW, lcd_data}, {22'd0, rs, rw, exp_db});
      end
      check({tag, " E"}, {31'd0, LCD_E}, {31'd0, (n >= 4 && n <= 15)});
      if (n >= 15 && n <= 17) check({tag, " rsp_valid"}, {31'd0, rsp_valid}, {31'd0, (rw && n == 16)});
    end
    check({tag, " latency"}, n, exp_lat);
  endtask

  task automatic reset_mid_pulse();
    wait_ready("rst");
    cmd_rs    = 1'b1;
    cmd_rw    = 1'b0;
    cmd_data  = 8'h41;
    cmd_valid = 1'b1;
    repeat (8) @(negedge clk);
    cmd_valid = 1'b0;
    check("rst pre_E", {31'd0, LCD_E}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst async_E", {31'd0, LCD_E}, 32'd0);
    check("rst async_bus", {23'd0, LCD_RW, lcd_data}, {23'd0, 1'b1, lcd_model});
    check("rst async_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    power_on_check("rst");
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_rs    = 1'b0;
    cmd_rw    = 1'b0;
    cmd_data  = 8'h00;
    lcd_model = 8'h5A;
    repeat (2) @(negedge clk);
    check("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset rsp", {23'd0, rsp_valid, rsp_data}, 32'd0);
    check("reset busy_timeout", {31'd0, busy_timeout}, 32'd0);
    check("reset ctrl", {29'd0, LCD_E, LCD_RS, LCD_RW}, 32'd1);
    check("reset bus", {24'd0, lcd_data}, {24'd0, lcd_model});
    power_on_check("init");

    do_xfer(1'b1, 1'b0, 8'h41, 76, 1'b0, "wr_41");
    do_xfer(1'b1, 1'b1, 8'h81, 26, 1'b0, "rd_5a");
    do_xfer(1'b0, 1'b0, 8'h01, 426, 1'b0, "clear");
    do_xfer(1'b0, 1'b0, 8'h38, 76, 1'b1, "fnset_hold");
    do_xfer(1'b0, 1'b0, 8'h02, 426, 1'b0, "home");
    do_xfer(1'b0, 1'b0, 8'h04, 76, 1'b0, "entry");
    do_xfer(1'b1, 1'b0, 8'h01, 76, 1'b0, "data_01");
    lcd_model = 8'hC3;
    do_xfer(1'b1, 1'b1, 8'h3C, 26, 1'b0, "rd_c3");
    lcd_model = 8'h5A;

    reset_mid_pulse();
    do_xfer(1'b1, 1'b0, 8'h41, 76, 1'b0, "post_rst");

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
